// File: rtl/ldpc_syndrome_gf2_check.sv
// ldpc_syndrome_gf2_check
// Receive-side GF(2) syndrome check. Each frame of codeword beats is XOR-folded
// into a WIDTH-bit syndrome. One result per frame reports the syndrome, a
// zero/pass flag, the saturating beat count and a sticky overflow flag.
// Input ready and output valid are both registered, so no combinational path
// runs from any input to any output.

module ldpc_syndrome_gf2_check #(
  parameter  int WIDTH     = 16,
  parameter  int MAX_BEATS = 64,
  localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_valid,
  input  logic             i_in_last,
  output logic             o_in_ready,
  output logic [WIDTH-1:0] o_out_syndrome,
  output logic             o_out_zero,
  output logic [CNT_W-1:0] o_out_beats,
  output logic             o_out_overflow,
  output logic             o_out_valid,
  input  logic             i_out_ready
);

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Running frame state
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             ovf_reg, ovf_next;

  // Registered result and handshake outputs
  logic [WIDTH-1:0] syndrome_reg, syndrome_next;
  logic             zero_reg, zero_next;
  logic [CNT_W-1:0] beats_reg, beats_next;
  logic             ovf_out_reg, ovf_out_next;
  logic             out_valid_reg, out_valid_next;
  logic             in_ready_reg, in_ready_next;

  logic             accept;
  logic             handshake;
  logic             first_beat;
  logic [WIDTH-1:0] acc_mix;

  assign accept     = i_in_valid && in_ready_reg;
  assign handshake  = out_valid_reg && i_out_ready;
  assign first_beat = (state_reg == ST_IDLE);

  // Per-bit GF(2) fold: the first beat of a frame seeds the accumulator,
  // later beats are XORed in. No carries cross bit boundaries.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fold
      assign acc_mix[gi] = first_beat ? i_in_data[gi] : (acc_reg[gi] ^ i_in_data[gi]);
    end
  endgenerate

  // State register and all datapath/output registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg     <= ST_START;
      acc_reg       <= '0;
      count_reg     <= '0;
      ovf_reg       <= 1'b0;
      syndrome_reg  <= '0;
      zero_reg      <= 1'b0;
      beats_reg     <= '0;
      ovf_out_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      count_reg     <= count_next;
      ovf_reg       <= ovf_next;
      syndrome_reg  <= syndrome_next;
      zero_reg      <= zero_next;
      beats_reg     <= beats_next;
      ovf_out_reg   <= ovf_out_next;
      out_valid_reg <= out_valid_next;
      in_ready_reg  <= in_ready_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_START:  state_next = ST_IDLE;
      ST_IDLE: begin
        if (accept) begin
          state_next = i_in_last ? ST_RESULT : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept && i_in_last) begin
          state_next = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (handshake) begin
          state_next = ST_IDLE;
        end
      end
      default:   state_next = ST_START;
    endcase
  end

  // Output and datapath next values; ready/valid follow the next state so
  // they can never both be high at once.
  always_comb begin
    acc_next       = acc_reg;
    count_next     = count_reg;
    ovf_next       = ovf_reg;
    syndrome_next  = syndrome_reg;
    zero_next      = zero_reg;
    beats_next     = beats_reg;
    ovf_out_next   = ovf_out_reg;
    in_ready_next  = (state_next == ST_IDLE) || (state_next == ST_ACCUM);
    out_valid_next = (state_next == ST_RESULT);

    if (accept && ((state_reg == ST_IDLE) || (state_reg == ST_ACCUM))) begin
      acc_next = acc_mix;
      if (first_beat) begin
        count_next = CNT_W'(1);
        ovf_next   = 1'b0;
      end else if (count_reg == CNT_W'(MAX_BEATS)) begin
        // Saturate the count; overflow stays set for the rest of the frame
        count_next = count_reg;
        ovf_next   = 1'b1;
      end else begin
        count_next = count_reg + CNT_W'(1);
      end

      if (i_in_last) begin
        syndrome_next = acc_mix;
        zero_next     = (acc_mix == '0);
        beats_next    = count_next;
        ovf_out_next  = ovf_next;
      end
    end
  end

  assign o_in_ready     = in_ready_reg;
  assign o_out_valid    = out_valid_reg;
  assign o_out_syndrome = syndrome_reg;
  assign o_out_zero     = zero_reg;
  assign o_out_beats    = beats_reg;
  assign o_out_overflow = ovf_out_reg;

endmodule

// File: tb/tb_ldpc_syndrome_gf2_check.sv
// Directed bench for ldpc_syndrome_gf2_check with MAX_BEATS=4 so the overflow
// path is reachable. Inputs change and outputs are sampled on the falling edge.

module tb_ldpc_syndrome_gf2_check;

  localparam int WIDTH     = 16;
  localparam int MAX_BEATS = 4;
  localparam int CNT_W     = $clog2(MAX_BEATS + 1);

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIDTH-1:0] out_syndrome;
  logic             out_zero;
  logic [CNT_W-1:0] out_beats;
  logic             out_overflow;
  logic             out_valid;
  logic             out_ready;

  int n_checks = 0;
  int n_pass   = 0;
  int n_results = 0;
  int n_both_high = 0;

  ldpc_syndrome_gf2_check #(
    .WIDTH     (WIDTH),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_in_data      (in_data),
    .i_in_valid     (in_valid),
    .i_in_last      (in_last),
    .o_in_ready     (in_ready),
    .o_out_syndrome (out_syndrome),
    .o_out_zero     (out_zero),
    .o_out_beats    (out_beats),
    .o_out_overflow (out_overflow),
    .o_out_valid    (out_valid),
    .i_out_ready    (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count result handshakes and watch that ready/valid never overlap
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) n_results <= n_results + 1;
    if (in_ready && out_valid) n_both_high <= n_both_high + 1;
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
      $display("ok   %-22s 0x%0h", tag, actual);
    end else begin
      $display("FAIL %-22s got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge
  // once the beat has been taken.
  task automatic send_beat(input logic [WIDTH-1:0] d, input logic l);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic check_result(input string tag, input logic [WIDTH-1:0] syn,
                              input logic zero, input logic [CNT_W-1:0] beats,
                              input logic ovf);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_syn"},   32'(out_syndrome), 32'(syn));
    check({tag, "_zero"},  32'(out_zero), 32'(zero));
    check({tag, "_beats"}, 32'(out_beats), 32'(beats));
    check({tag, "_ovf"},   32'(out_overflow), 32'(ovf));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'hDEAD;
    in_last   = 1'b1;
    out_ready = 1'b1;

    // Reset held 3 cycles with valid asserted
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_syn",   32'(out_syndrome), 32'd0);
    check("rst_zero",  32'(out_zero), 32'd0);
    check("rst_beats", 32'(out_beats), 32'd0);
    check("rst_ovf",   32'(out_overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", 32'(in_ready), 32'd1);
    check("rel_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    in_last  = 1'b0;

    // Frame 1: 0x1234 ^ 0x00FF ^ 0x1200 = 0x00CB
    send_beat(16'h1234, 1'b0);
    send_beat(16'h00FF, 1'b0);
    send_beat(16'h1200, 1'b1);
    check_result("f1", 16'h00CB, 1'b0, CNT_W'(3), 1'b0);
    @(negedge clk);
    check("f1_done_valid", 32'(out_valid), 32'd0);
    check("f1_done_ready", 32'(in_ready), 32'd1);

    // Frame 2: valid codeword with a 2-cycle gap
    send_beat(16'hA5A5, 1'b0);
    repeat (2) @(negedge clk);
    send_beat(16'h5A5A, 1'b0);
    send_beat(16'hFFFF, 1'b1);
    check_result("f2", 16'h0000, 1'b1, CNT_W'(3), 1'b0);
    @(negedge clk);

    // Frame 3 with backpressure: 0x0003 ^ 0x0004 = 0x0007
    out_ready = 1'b0;
    send_beat(16'h0003, 1'b0);
    send_beat(16'h0004, 1'b1);
    in_valid = 1'b1;
    in_data  = 16'h0001;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_result("bp_hold", 16'h0007, 1'b0, CNT_W'(2), 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_valid", 32'(out_valid), 32'd0);
    check("bp_rel_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_result("f4", 16'h0001, 1'b0, CNT_W'(1), 1'b0);
    @(negedge clk);

    // Overflow: six beats of 0x0001 with MAX_BEATS=4
    for (int i = 0; i < 5; i++) send_beat(16'h0001, 1'b0);
    send_beat(16'h0001, 1'b1);
    check_result("ovf", 16'h0000, 1'b1, CNT_W'(4), 1'b1);
    @(negedge clk);
    send_beat(16'h0002, 1'b1);
    check_result("post_ovf", 16'h0002, 1'b0, CNT_W'(1), 1'b0);
    @(negedge clk);

    // Reset mid-frame discards the partial frame
    send_beat(16'hFFFF, 1'b0);
    send_beat(16'h0F0F, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_syn",   32'(out_syndrome), 32'd0);
    @(negedge clk);
    send_beat(16'h0003, 1'b1);
    check_result("mid_rst", 16'h0003, 1'b0, CNT_W'(1), 1'b0);
    repeat (4) @(negedge clk);
    check("idle_valid", 32'(out_valid), 32'd0);

    check("result_count", 32'(n_results), 32'd7);
    check("ready_valid_overlap", 32'(n_both_high), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global bound on run time
  initial begin
    #100000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1);
  end

endmodule
